// File: rtl/control_unit_param.sv
// control_unit_param: multi-cycle control FSM for the 8-bit accumulator CPU datapath.
// Fetches and decodes opcodes and drives the datapath load, bus-select and write strobes.
//
// Parameters:
//   MEM_WAIT    wait cycles between MAR load and memory data valid (1..15)
// Build option:
//   CU_MEM_READY_EN  when defined, adds the Mem_Ready input and each *_WAIT state lasts
//                    until Mem_Ready=1 (MEM_WAIT is then ignored)
// Ports:
//   Clk, Reset          clock (rising edge), asynchronous active-low reset
//   IR                  current opcode
//   CCR_Result          flags {N,Z,V,C}, bit 3 = N
//   Mem_Ready           memory data valid (CU_MEM_READY_EN only)
//   IR_Load .. write    datapath strobes
//   ALU_Sel             ALU operation
//   Bus1_Sel            Bus1 source: 00 PC, 01 A, 10 B
//   Bus2_Sel            Bus2 source: 00 ALU, 01 Bus1, 10 memory
//   Illegal             one-cycle pulse in DECODE on an unknown opcode
module control_unit_param #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
`ifdef CU_MEM_READY_EN
  input  logic       Mem_Ready,
`endif
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       A_Load,
  output logic       B_Load,
  output logic       CCR_Load,
  output logic       write,
  output logic [2:0] ALU_Sel,
  output logic [1:0] Bus1_Sel,
  output logic [1:0] Bus2_Sel,
  output logic       Illegal
);

  localparam logic [7:0] LdaImm = 8'h86;
  localparam logic [7:0] LdaDir = 8'h87;
  localparam logic [7:0] LdbImm = 8'h88;
  localparam logic [7:0] LdbDir = 8'h89;
  localparam logic [7:0] StaDir = 8'h96;
  localparam logic [7:0] StbDir = 8'h97;
  localparam logic [7:0] IncB   = 8'h47;
  localparam logic [7:0] DecB   = 8'h49;

  typedef enum logic [3:0] {
    StFMar, StFWait, StFLd, StDecode, StOMar, StOWait, StOLd, StDWait, StDXfer, StAluEx
  } state_e;

  state_e state_q, state_d;

  // Opcode classes, decoded straight from IR (stable from DECODE onwards).
  logic op_imm, op_dir, op_alu, op_br, op_known;
  assign op_imm   = (IR == LdaImm) || (IR == LdbImm);
  assign op_dir   = (IR == LdaDir) || (IR == LdbDir) || (IR == StaDir) || (IR == StbDir);
  assign op_alu   = (IR >= 8'h42) && (IR <= 8'h49);
  assign op_br    = (IR >= 8'h20) && (IR <= 8'h28);
  assign op_known = op_imm | op_dir | op_alu | op_br;

  logic br_taken;
  always_comb begin
    br_taken = 1'b0;
    unique case (IR)
      8'h20:   br_taken = 1'b1;
      8'h21:   br_taken = CCR_Result[3];
      8'h22:   br_taken = ~CCR_Result[3];
      8'h23:   br_taken = CCR_Result[2];
      8'h24:   br_taken = ~CCR_Result[2];
      8'h25:   br_taken = CCR_Result[1];
      8'h26:   br_taken = ~CCR_Result[1];
      8'h27:   br_taken = CCR_Result[0];
      8'h28:   br_taken = ~CCR_Result[0];
      default: br_taken = 1'b0;
    endcase
  end

  logic in_wait, wait_done;
  assign in_wait = (state_q == StFWait) || (state_q == StOWait) || (state_q == StDWait);

`ifdef CU_MEM_READY_EN
  assign wait_done = Mem_Ready;
  logic unused_mem_wait;
  assign unused_mem_wait = ^(4'(MEM_WAIT));
`else
  localparam logic [3:0] WaitLast = 4'(MEM_WAIT - 1);
  logic [3:0] wait_cnt_q, wait_cnt_d;
  assign wait_done = (wait_cnt_q == WaitLast);
  // Counts while waiting; zero everywhere else, so every wait entry starts at 0.
  assign wait_cnt_d = (in_wait && !wait_done) ? wait_cnt_q + 4'd1 : 4'd0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFMar:   state_d = StFWait;
      StFWait:  if (wait_done) state_d = StFLd;
      StFLd:    state_d = StDecode;
      StDecode: begin
        if (op_alu)                         state_d = StAluEx;
        else if (op_imm || op_dir || op_br) state_d = StOMar;
        else                                state_d = StFMar;
      end
      StOMar:   state_d = StOWait;
      StOWait:  if (wait_done) state_d = StOLd;
      StOLd:    state_d = op_dir ? StDWait : StFMar;
      StDWait:  if (wait_done) state_d = StDXfer;
      StDXfer:  state_d = StFMar;
      StAluEx:  state_d = StFMar;
      default:  state_d = StFMar;
    endcase
  end

  // Registered outputs are computed for the state being entered.
  logic       ir_load_d, mar_load_d, pc_inc_d, a_load_d, b_load_d, ccr_load_d, write_d;
  logic       br_ld_d;
  logic [2:0] alu_sel_d;
  logic [1:0] bus1_d, bus2_d;

  always_comb begin
    ir_load_d  = 1'b0;
    mar_load_d = 1'b0;
    pc_inc_d   = 1'b0;
    a_load_d   = 1'b0;
    b_load_d   = 1'b0;
    ccr_load_d = 1'b0;
    write_d    = 1'b0;
    br_ld_d    = 1'b0;
    alu_sel_d  = 3'b000;
    bus1_d     = 2'b00;
    bus2_d     = 2'b00;
    unique case (state_d)
      StFMar, StOMar: begin
        mar_load_d = 1'b1;
        bus2_d     = 2'b01;
      end
      StFLd: begin
        ir_load_d = 1'b1;
        pc_inc_d  = 1'b1;
        bus2_d    = 2'b10;
      end
      StOLd: begin
        if (op_imm) begin
          bus2_d   = 2'b10;
          pc_inc_d = 1'b1;
          a_load_d = (IR == LdaImm);
          b_load_d = (IR == LdbImm);
        end else if (op_dir) begin
          mar_load_d = 1'b1;
          bus2_d     = 2'b10;
          pc_inc_d   = 1'b1;
        end else begin
          // Branch: the taken decision is made from CCR_Result during O_LD itself.
          br_ld_d = 1'b1;
        end
      end
      StDXfer: begin
        if ((IR == LdaDir) || (IR == LdbDir)) begin
          bus2_d   = 2'b10;
          a_load_d = (IR == LdaDir);
          b_load_d = (IR == LdbDir);
        end else begin
          write_d = 1'b1;
          bus1_d  = (IR == StbDir) ? 2'b10 : 2'b01;
        end
      end
      StAluEx: begin
        ccr_load_d = 1'b1;
        alu_sel_d  = 3'(IR - 8'h42);
        if ((IR == IncB) || (IR == DecB)) begin
          bus1_d   = 2'b10;
          b_load_d = 1'b1;
        end else begin
          bus1_d   = 2'b01;
          a_load_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  logic       ir_load_q, mar_load_q, pc_inc_q, a_load_q, b_load_q, ccr_load_q, write_q;
  logic       br_ld_q;
  logic [2:0] alu_sel_q;
  logic [1:0] bus1_q, bus2_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= StFMar;
`ifndef CU_MEM_READY_EN
      wait_cnt_q <= 4'd0;
`endif
      ir_load_q  <= 1'b0;
      mar_load_q <= 1'b1;
      pc_inc_q   <= 1'b0;
      a_load_q   <= 1'b0;
      b_load_q   <= 1'b0;
      ccr_load_q <= 1'b0;
      write_q    <= 1'b0;
      br_ld_q    <= 1'b0;
      alu_sel_q  <= 3'b000;
      bus1_q     <= 2'b00;
      bus2_q     <= 2'b01;
    end else begin
      state_q    <= state_d;
`ifndef CU_MEM_READY_EN
      wait_cnt_q <= wait_cnt_d;
`endif
      ir_load_q  <= ir_load_d;
      mar_load_q <= mar_load_d;
      pc_inc_q   <= pc_inc_d;
      a_load_q   <= a_load_d;
      b_load_q   <= b_load_d;
      ccr_load_q <= ccr_load_d;
      write_q    <= write_d;
      br_ld_q    <= br_ld_d;
      alu_sel_q  <= alu_sel_d;
      bus1_q     <= bus1_d;
      bus2_q     <= bus2_d;
    end
  end

  assign IR_Load  = ir_load_q;
  assign MAR_Load = mar_load_q;
  assign PC_Load  = br_ld_q & br_taken;
  assign PC_Inc   = pc_inc_q | (br_ld_q & ~br_taken);
  assign A_Load   = a_load_q;
  assign B_Load   = b_load_q;
  assign CCR_Load = ccr_load_q;
  assign write    = write_q;
  assign ALU_Sel  = alu_sel_q;
  assign Bus1_Sel = bus1_q;
  assign Bus2_Sel = bus2_q | ((br_ld_q & br_taken) ? 2'b10 : 2'b00);
  assign Illegal  = (state_q == StDecode) & ~op_known;

endmodule

// File: tb/tb_control_unit_param.sv
// Self-checking bench for control_unit_param: a per-cycle reference model builds the expected
// output vector of every cycle of each instruction from the opcode tables and wait rules.
module tb_control_unit_param;

  localparam int unsigned MW = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] IR = 8'h00;
  logic [3:0] CCR_Result = 4'h0;
`ifdef CU_MEM_READY_EN
  logic       mem_ready = 1'b0;
`endif
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write, Illegal;
  logic [2:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;

  control_unit_param #(.MEM_WAIT(MW)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .IR         (IR),
    .CCR_Result (CCR_Result),
`ifdef CU_MEM_READY_EN
    .Mem_Ready  (mem_ready),
`endif
    .IR_Load    (IR_Load),
    .MAR_Load   (MAR_Load),
    .PC_Load    (PC_Load),
    .PC_Inc     (PC_Inc),
    .A_Load     (A_Load),
    .B_Load     (B_Load),
    .CCR_Load   (CCR_Load),
    .write      (write),
    .ALU_Sel    (ALU_Sel),
    .Bus1_Sel   (Bus1_Sel),
    .Bus2_Sel   (Bus2_Sel),
    .Illegal    (Illegal)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       ir_load, mar_load, pc_load, pc_inc, a_load, b_load, ccr_load, wr;
    logic [2:0] alu;
    logic [1:0] b1, b2;
    logic       ill;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int force_fwait = 0;

  function automatic vec_t v_mar();
    vec_t e = '0;
    e.mar_load = 1'b1;
    e.b2       = 2'b01;
    return e;
  endfunction

  function automatic int wl_pick();
`ifdef CU_MEM_READY_EN
    return $urandom_range(1, 4);
`else
    return MW;
`endif
  endfunction

  task automatic check(input string tag, input vec_t exp);
    vec_t obs;
    obs = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write,
           ALU_Sel, Bus1_Sel, Bus2_Sel, Illegal};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (IR=%h CCR=%h)", tag, obs, exp, IR, CCR_Result);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check mid-cycle, move to next falling edge.
  task automatic step(input string tag, input vec_t exp, input logic [7:0] ir_v,
                      input logic [3:0] ccr_v);
    IR = ir_v;
    CCR_Result = ccr_v;
    #2 check(tag, exp);
    @(negedge Clk);
`ifdef CU_MEM_READY_EN
    mem_ready = 1'($urandom);
`endif
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      IR = 8'($urandom);
      CCR_Result = 4'($urandom);
      #2 check("reset", v_mar());
      @(negedge Clk);
    end
    Reset = 1'b1;
  endtask

  // Wait phase of wl cycles; ready is raised only on the last one. abort_at >= 0 asserts reset
  // in that wait cycle instead.
  task automatic wait_phase(input string tag, input int wl, input logic [7:0] ir_v,
                            input int abort_at, output bit aborted);
    aborted = 1'b0;
    for (int i = 0; i < wl; i++) begin
      if (i == abort_at) begin
        do_reset(3);
        aborted = 1'b1;
        return;
      end
`ifdef CU_MEM_READY_EN
      mem_ready = (i == wl - 1);
`endif
      step(tag, '0, ir_v, 4'($urandom));
    end
  endtask

  task automatic run_instr(input logic [7:0] op, input logic [3:0] ccr_ld, input bit abort);
    vec_t e;
    bit   ab, imm, dir, alu, br, known, taken;
    int   wl;
    imm   = (op == 8'h86) || (op == 8'h88);
    dir   = (op == 8'h87) || (op == 8'h89) || (op == 8'h96) || (op == 8'h97);
    alu   = (op >= 8'h42) && (op <= 8'h49);
    br    = (op >= 8'h20) && (op <= 8'h28);
    known = imm || dir || alu || br;

    step("f_mar", v_mar(), 8'($urandom), 4'($urandom));
    wl = (force_fwait != 0) ? force_fwait : wl_pick();
    force_fwait = 0;
    wait_phase("f_wait", wl, 8'($urandom), -1, ab);
    e = '0; e.ir_load = 1'b1; e.pc_inc = 1'b1; e.b2 = 2'b10;
    step("f_ld", e, 8'($urandom), 4'($urandom));
    e = '0; e.ill = !known;
    step("decode", e, op, 4'($urandom));
    if (!known) return;

    if (alu) begin
      e = '0;
      e.ccr_load = 1'b1;
      e.alu      = 3'(op - 8'h42);
      if (op == 8'h47 || op == 8'h49) begin
        e.b1 = 2'b10; e.b_load = 1'b1;
      end else begin
        e.b1 = 2'b01; e.a_load = 1'b1;
      end
      step("alu_ex", e, op, 4'($urandom));
      return;
    end

    step("o_mar", v_mar(), op, 4'($urandom));
    wait_phase("o_wait", wl_pick(), op, -1, ab);
    e = '0;
    if (imm) begin
      e.b2 = 2'b10; e.pc_inc = 1'b1;
      e.a_load = (op == 8'h86); e.b_load = (op == 8'h88);
    end else if (dir) begin
      e.mar_load = 1'b1; e.b2 = 2'b10; e.pc_inc = 1'b1;
    end else begin
      case (op)
        8'h20:   taken = 1'b1;
        8'h21:   taken = ccr_ld[3];
        8'h22:   taken = !ccr_ld[3];
        8'h23:   taken = ccr_ld[2];
        8'h24:   taken = !ccr_ld[2];
        8'h25:   taken = ccr_ld[1];
        8'h26:   taken = !ccr_ld[1];
        8'h27:   taken = ccr_ld[0];
        default: taken = !ccr_ld[0];
      endcase
      if (taken) begin
        e.pc_load = 1'b1; e.b2 = 2'b10;
      end else begin
        e.pc_inc = 1'b1;
      end
    end
    step("o_ld", e, op, ccr_ld);
    if (!dir) return;

    wait_phase("d_wait", abort ? 3 : wl_pick(), op, abort ? 1 : -1, ab);
    if (ab) return;
    e = '0;
    if (op == 8'h87 || op == 8'h89) begin
      e.b2 = 2'b10; e.a_load = (op == 8'h87); e.b_load = (op == 8'h89);
    end else begin
      e.wr = 1'b1; e.b1 = (op == 8'h97) ? 2'b10 : 2'b01;
    end
    step("d_xfer", e, op, 4'($urandom));
  endtask

  logic [7:0] pool [23] = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97,
                            8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49,
                            8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};

  initial begin
    logic [3:0] ccr;
    logic [7:0] op;
    int         bitpos;
    @(negedge Clk);
    do_reset(3);

`ifdef CU_MEM_READY_EN
    force_fwait = 6;
`endif
    run_instr(8'h86, 4'h0, 1'b0);
    run_instr(8'h96, 4'h0, 1'b0);

    // Every branch opcode, tested flag both high and low.
    for (int b = 0; b < 9; b++) begin
      bitpos = (b == 0) ? 0 : 3 - (b - 1) / 2;
      for (int hl = 0; hl < 2; hl++) begin
        ccr = 4'($urandom);
        ccr[bitpos] = hl[0];
        run_instr(8'(8'h20 + b), ccr, 1'b0);
      end
    end

    for (int a = 0; a < 8; a++) run_instr(8'(8'h42 + a), 4'h0, 1'b0);
    run_instr(8'h87, 4'h0, 1'b0);
    run_instr(8'h88, 4'h0, 1'b0);
    run_instr(8'h89, 4'h0, 1'b0);
    run_instr(8'h97, 4'h0, 1'b0);
    run_instr(8'hFF, 4'h0, 1'b0);
    run_instr(8'h00, 4'h0, 1'b0);
    run_instr(8'h96, 4'h0, 1'b1);
    run_instr(8'h97, 4'h0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) op = 8'($urandom);
      else                           op = pool[$urandom_range(0, 22)];
      run_instr(op, 4'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
